potential_bank: RTL and testbench
=================================

POTENTIAL_BANK -- requirements
Module: potential_bank

Interface
REQ-001 Parameter: GROUPS, default 8, number of 16-neuron groups stored; power of two, at least 2; GW = log2(GROUPS).
REQ-002 Parameter: NEURONS, default 16, neurons per group; fixed at 16.
REQ-003 Parameter: PW, default 8, membrane potential width per neuron.
REQ-004 Parameter: BW, default 4, beta width per neuron.
REQ-005 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: clear_req  input  1  request to zero all stored potentials.
REQ-008 Port: busy  output  1  high while the clear sweep runs.
REQ-009 Port: load_valid  input  1  load request.
REQ-010 Port: load_ready  output  1  load request can be accepted.
REQ-011 Port: load_group  input  GW  group to load.
REQ-012 Port: load_rsp_valid  output  1  load response strobe.
REQ-013 Port: load_potential_out  output  NEURONS*PW  stored potentials of the loaded group; neuron i occupies bits [i*PW+PW-1 : i*PW].
REQ-014 Port: load_beta_out  output  NEURONS*BW  stored betas of the loaded group; neuron i occupies bits [i*BW+BW-1 : i*BW].
REQ-015 Port: save_valid  input  1  save request.
REQ-016 Port: save_ready  output  1  save request can be accepted.
REQ-017 Port: save_group  input  GW  group to save.
REQ-018 Port: save_potential_in  input  NEURONS*PW  post-spike-reset potentials to store, using the same packing as REQ-013.
REQ-019 Port: beta_we  input  1  beta write enable.
REQ-020 Port: beta_group  input  GW  group whose betas are written.
REQ-021 Port: beta_data  input  NEURONS*BW  beta values, using the same packing as REQ-014.

Function
REQ-022 Storage: GROUPS x NEURONS*PW potential registers and GROUPS x NEURONS*BW beta registers.
REQ-023 FSM states: IDLE and CLEAR; there is also a sweep counter clr_cnt of width GW.
REQ-024 load_ready = save_ready = (state == IDLE); busy = (state == CLEAR).
REQ-025 A load is accepted on the edge where load_valid and load_ready are both high.
REQ-026 On the cycle after an accepted load, load_rsp_valid is high for exactly one cycle, and load_potential_out/load_beta_out present the registered data for load_group.
REQ-027 load_potential_out and load_beta_out hold their value until the next accepted load.
REQ-028 Back-to-back loads (one per cycle) are supported with no bubble.
REQ-029 A save is accepted on the edge where save_valid and save_ready are both high, and save_potential_in is written to save_group at that edge.
REQ-030 Save/load collision: if a save and a load to the same group are accepted on the same edge, the load response carries save_potential_in (new data forwarded).
REQ-031 If a save and a load to different groups are accepted on the same edge, both complete independently.
REQ-032 Beta write: beta_we writes beta_data to beta_group at the edge, in both IDLE and CLEAR; there is no handshake.
REQ-033 If a beta write and an accepted load target the same group on the same edge, the load response carries beta_data (forwarded).
REQ-034 If clear_req is high in IDLE, state goes to CLEAR at that edge with clr_cnt = 0; a load or save accepted on that same edge completes normally and is ordered before the sweep.
REQ-035 In CLEAR, each edge zeroes the potentials of group clr_cnt and increments clr_cnt; when clr_cnt = GROUPS-1, state returns to IDLE at that edge.
REQ-036 busy is high for exactly GROUPS cycles per clear.
REQ-037 clear_req is ignored while in CLEAR; it is not queued.
REQ-038 In CLEAR, load_valid and save_valid are not accepted, and the requester holds its request.
REQ-039 Betas are never altered by the sweep.
REQ-040 No arithmetic on data: values are stored and returned bit-exact.

Reset
REQ-041 While reset is low, asynchronously: all potentials = 0, all betas = 0, state = IDLE, clr_cnt = 0, load_rsp_valid = 0, load_potential_out = 0, load_beta_out = 0.
REQ-042 Reset asserted mid-sweep aborts the sweep, and all storage reads 0 after reset.
REQ-043 After reset deasserts, busy = 0 and load_ready = save_ready = 1 in the first cycle.

Verification
REQ-044 Reset then load group 3 -> next cycle load_rsp_valid = 1, potential = 128'h0, beta = 64'h0.
REQ-045 Beta write group 2 = 64'h0123456789ABCDEF and save group 2 = 128'hA5 repeated; load group 2 on a later cycle -> response shows exactly those values, and load_rsp_valid is high for a single cycle.
REQ-046 Same-edge save group 5 = 128'h7F.. with load group 5 (old value 0) -> response = 128'h7F..; a same-edge save to group 6 with load of group 5 -> response = old group 5 value.
REQ-047 All groups filled with nonzero data, then clear_req -> busy high for exactly 8 cycles and ready low throughout; a load_valid held during the sweep is accepted on the first IDLE cycle and returns 0; betas are unchanged.
REQ-048 Assert reset on clr_cnt = 3 mid-sweep -> all outputs 0 immediately; after release, all groups load as 0 and state is IDLE.
REQ-049 Loads to groups 0..7 on 8 consecutive cycles -> 8 consecutive response cycles in order, with no gaps.

Source files
------------

// File: rtl/potential_bank.sv
// Banked storage of per-neuron membrane potentials and betas, with a
// registered load port, a write-through save port and a background clear sweep.
module potential_bank #(
    parameter int unsigned GROUPS  = 8,
    parameter int unsigned NEURONS = 16,
    parameter int unsigned PW      = 8,
    parameter int unsigned BW      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    output logic                         busy,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [$clog2(GROUPS)-1:0]    load_group,
    output logic                         load_rsp_valid,
    output logic [NEURONS*PW-1:0]        load_potential_out,
    output logic [NEURONS*BW-1:0]        load_beta_out,
    input  logic                         save_valid,
    output logic                         save_ready,
    input  logic [$clog2(GROUPS)-1:0]    save_group,
    input  logic [NEURONS*PW-1:0]        save_potential_in,
    input  logic                         beta_we,
    input  logic [$clog2(GROUPS)-1:0]    beta_group,
    input  logic [NEURONS*BW-1:0]        beta_data
);

    localparam int unsigned GW   = $clog2(GROUPS);
    localparam int unsigned POTW = NEURONS * PW;
    localparam int unsigned BETW = NEURONS * BW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   clr_cnt_q, clr_cnt_d;

    logic [POTW-1:0] pot_q  [GROUPS];
    logic [BETW-1:0] beta_q [GROUPS];

    logic            rsp_valid_q, rsp_valid_d;
    logic [POTW-1:0] pot_out_q, pot_out_d;
    logic [BETW-1:0] beta_out_q, beta_out_d;

    logic            load_fire;
    logic            save_fire;

    assign load_ready = (state_q == IDLE);
    assign save_ready = (state_q == IDLE);
    assign busy       = (state_q == CLEAR);
    assign load_fire  = load_valid && (state_q == IDLE);
    assign save_fire  = save_valid && (state_q == IDLE);

    assign load_rsp_valid     = rsp_valid_q;
    assign load_potential_out = pot_out_q;
    assign load_beta_out      = beta_out_q;

    // State and sweep counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state: a clear request starts a one-group-per-cycle sweep
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + GW'(1);
                if (clr_cnt_q == GW'(GROUPS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load response; same-edge writes to the loaded group are forwarded
    always_comb begin
        rsp_valid_d = load_fire;
        pot_out_d   = pot_out_q;
        beta_out_d  = beta_out_q;
        if (load_fire) begin
            if (save_fire && (save_group == load_group)) begin
                pot_out_d = save_potential_in;
            end else begin
                pot_out_d = pot_q[load_group];
            end
            if (beta_we && (beta_group == load_group)) begin
                beta_out_d = beta_data;
            end else begin
                beta_out_d = beta_q[load_group];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            pot_out_q   <= '0;
            beta_out_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            pot_out_q   <= pot_out_d;
            beta_out_q  <= beta_out_d;
        end
    end

    // Storage; saves only land in IDLE, so they never race the sweep
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned g = 0; g < GROUPS; g++) begin
                pot_q[g]  <= '0;
                beta_q[g] <= '0;
            end
        end else begin
            if (save_fire) begin
                pot_q[save_group] <= save_potential_in;
            end
            if (state_q == CLEAR) begin
                pot_q[clr_cnt_q] <= '0;
            end
            if (beta_we) begin
                beta_q[beta_group] <= beta_data;
            end
        end
    end

endmodule

// File: tb/tb_potential_bank.sv
// Directed bench for potential_bank: reset, save/load, forwarding, clear sweep,
// mid-sweep reset and back-to-back loads.
module tb_potential_bank;

    logic         clk;
    logic         reset;
    logic         clear_req;
    logic         busy;
    logic         load_valid;
    logic         load_ready;
    logic [2:0]   load_group;
    logic         load_rsp_valid;
    logic [127:0] load_potential_out;
    logic [63:0]  load_beta_out;
    logic         save_valid;
    logic         save_ready;
    logic [2:0]   save_group;
    logic [127:0] save_potential_in;
    logic         beta_we;
    logic [2:0]   beta_group;
    logic [63:0]  beta_data;

    int vectors;
    int miscompares;

    potential_bank #(
        .GROUPS (8),
        .NEURONS(16),
        .PW     (8),
        .BW     (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clear_req         (clear_req),
        .busy              (busy),
        .load_valid        (load_valid),
        .load_ready        (load_ready),
        .load_group        (load_group),
        .load_rsp_valid    (load_rsp_valid),
        .load_potential_out(load_potential_out),
        .load_beta_out     (load_beta_out),
        .save_valid        (save_valid),
        .save_ready        (save_ready),
        .save_group        (save_group),
        .save_potential_in (save_potential_in),
        .beta_we           (beta_we),
        .beta_group        (beta_group),
        .beta_data         (beta_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pot_pat(input int g);
        logic [7:0] b;
        b = 8'h30 + 8'(g);
        return {16{b}};
    endfunction

    function automatic logic [63:0] beta_pat(input int g);
        logic [3:0] b;
        b = 4'(g) ^ 4'hA;
        return {16{b}};
    endfunction

    task automatic idle_inputs();
        clear_req         = 1'b0;
        load_valid        = 1'b0;
        load_group        = '0;
        save_valid        = 1'b0;
        save_group        = '0;
        save_potential_in = '0;
        beta_we           = 1'b0;
        beta_group        = '0;
        beta_data         = '0;
    endtask

    task automatic fill_all();
        for (int g = 0; g < 8; g++) begin
            save_valid        = 1'b1;
            save_group        = 3'(g);
            save_potential_in = pot_pat(g);
            beta_we           = 1'b1;
            beta_group        = 3'(g);
            beta_data         = beta_pat(g);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({load_rsp_valid, load_potential_out, load_beta_out, busy} !== 194'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got rsp=%b pot=%h beta=%h busy=%b exp all zero",
                     load_rsp_valid, load_potential_out, load_beta_out, busy);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, load_ready, save_ready} !== 3'b011) begin
            miscompares++;
            $display("FAIL post_reset_ready got busy/lr/sr=%b exp 011", {busy, load_ready, save_ready});
        end
        load_valid = 1'b1;
        load_group = 3'd3;
        tick();
        load_valid = 1'b0;
        vectors++;
        if ({load_rsp_valid, load_potential_out, load_beta_out} !== {1'b1, 128'h0, 64'h0}) begin
            miscompares++;
            $display("FAIL reset_load3 got rsp=%b pot=%h beta=%h exp rsp=1 zeros",
                     load_rsp_valid, load_potential_out, load_beta_out);
        end
    endtask

    task automatic test_save_load();
        beta_we           = 1'b1;
        beta_group        = 3'd2;
        beta_data         = 64'h0123456789ABCDEF;
        save_valid        = 1'b1;
        save_group        = 3'd2;
        save_potential_in = {16{8'hA5}};
        tick();
        idle_inputs();
        tick();
        vectors++;
        if (load_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_rsp got %b exp 0", load_rsp_valid);
        end
        load_valid = 1'b1;
        load_group = 3'd2;
        tick();
        load_valid = 1'b0;
        vectors++;
        if ({load_rsp_valid, load_potential_out, load_beta_out} !==
            {1'b1, {16{8'hA5}}, 64'h0123456789ABCDEF}) begin
            miscompares++;
            $display("FAIL load2 got rsp=%b pot=%h beta=%h exp rsp=1 pot=a5.. beta=0123456789abcdef",
                     load_rsp_valid, load_potential_out, load_beta_out);
        end
        tick();
        vectors++;
        if ({load_rsp_valid, load_potential_out} !== {1'b0, {16{8'hA5}}}) begin
            miscompares++;
            $display("FAIL load2_hold got rsp=%b pot=%h exp rsp=0 pot held a5..",
                     load_rsp_valid, load_potential_out);
        end
    endtask

    task automatic test_collision();
        save_valid        = 1'b1;
        save_group        = 3'd5;
        save_potential_in = {16{8'h7F}};
        load_valid        = 1'b1;
        load_group        = 3'd5;
        tick();
        vectors++;
        if ({load_rsp_valid, load_potential_out} !== {1'b1, {16{8'h7F}}}) begin
            miscompares++;
            $display("FAIL fwd_same_group got rsp=%b pot=%h exp 7f..", load_rsp_valid, load_potential_out);
        end
        save_group        = 3'd6;
        save_potential_in = {16{8'h11}};
        load_group        = 3'd5;
        tick();
        vectors++;
        if ({load_rsp_valid, load_potential_out} !== {1'b1, {16{8'h7F}}}) begin
            miscompares++;
            $display("FAIL diff_group got rsp=%b pot=%h exp 7f..", load_rsp_valid, load_potential_out);
        end
        save_valid = 1'b0;
        load_group = 3'd6;
        beta_we    = 1'b1;
        beta_group = 3'd6;
        beta_data  = 64'hFEDCBA9876543210;
        tick();
        idle_inputs();
        vectors++;
        if ({load_rsp_valid, load_potential_out, load_beta_out} !==
            {1'b1, {16{8'h11}}, 64'hFEDCBA9876543210}) begin
            miscompares++;
            $display("FAIL beta_fwd got rsp=%b pot=%h beta=%h exp rsp=1 pot=11.. beta=fedcba9876543210",
                     load_rsp_valid, load_potential_out, load_beta_out);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        fill_all();
        clear_req = 1'b1;
        tick();
        clear_req   = 1'b0;
        load_valid  = 1'b1;
        load_group  = 3'd1;
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            busy_cycles++;
            vectors++;
            if ({load_ready, save_ready, load_rsp_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL sweep_ready cycle %0d got lr/sr/rsp=%b exp 000",
                         i, {load_ready, save_ready, load_rsp_valid});
            end
            clear_req = (i == 2);
            tick();
        end
        clear_req = 1'b0;
        vectors++;
        if (busy_cycles !== 8) begin
            miscompares++;
            $display("FAIL busy_len got %0d exp 8", busy_cycles);
        end
        tick();
        load_valid = 1'b0;
        vectors++;
        if ({load_rsp_valid, load_potential_out, load_beta_out} !== {1'b1, 128'h0, beta_pat(1)}) begin
            miscompares++;
            $display("FAIL held_load got rsp=%b pot=%h beta=%h exp rsp=1 pot=0 beta=%h",
                     load_rsp_valid, load_potential_out, load_beta_out, beta_pat(1));
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_not_requeued got busy=%b exp 0", busy);
        end
        for (int g = 0; g < 8; g++) begin
            load_valid = 1'b1;
            load_group = 3'(g);
            tick();
            vectors++;
            if ({load_potential_out, load_beta_out} !== {128'h0, beta_pat(g)}) begin
                miscompares++;
                $display("FAIL cleared_g%0d got pot=%h beta=%h exp pot=0 beta=%h",
                         g, load_potential_out, load_beta_out, beta_pat(g));
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        fill_all();
        clear_req  = 1'b1;
        load_valid = 1'b1;
        load_group = 3'd7;
        tick();
        idle_inputs();
        vectors++;
        if ({load_rsp_valid, load_potential_out, busy} !== {1'b1, pot_pat(7), 1'b1}) begin
            miscompares++;
            $display("FAIL load_with_clear got rsp=%b pot=%h busy=%b exp rsp=1 pot=%h busy=1",
                     load_rsp_valid, load_potential_out, busy, pot_pat(7));
        end
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if ({load_rsp_valid, load_potential_out, load_beta_out, busy, load_ready} !== {194'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_sweep_reset got rsp=%b pot=%h beta=%h busy=%b lr=%b exp zeros lr=1",
                     load_rsp_valid, load_potential_out, load_beta_out, busy, load_ready);
        end
        tick();
        reset = 1'b1;
        #1;
        for (int g = 0; g < 8; g++) begin
            load_valid = 1'b1;
            load_group = 3'(g);
            tick();
            vectors++;
            if ({load_rsp_valid, load_potential_out, load_beta_out, busy} !== {1'b1, 193'h0}) begin
                miscompares++;
                $display("FAIL after_reset_g%0d got rsp=%b pot=%h beta=%h busy=%b exp rsp=1 zeros",
                         g, load_rsp_valid, load_potential_out, load_beta_out, busy);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        fill_all();
        for (int g = 0; g < 8; g++) begin
            load_valid = 1'b1;
            load_group = 3'(g);
            tick();
            vectors++;
            if ({load_rsp_valid, load_potential_out, load_beta_out} !== {1'b1, pot_pat(g), beta_pat(g)}) begin
                miscompares++;
                $display("FAIL b2b_g%0d got rsp=%b pot=%h beta=%h exp rsp=1 pot=%h beta=%h",
                         g, load_rsp_valid, load_potential_out, load_beta_out, pot_pat(g), beta_pat(g));
            end
        end
        idle_inputs();
        tick();
        vectors++;
        if ({load_rsp_valid, load_potential_out} !== {1'b0, pot_pat(7)}) begin
            miscompares++;
            $display("FAIL b2b_end got rsp=%b pot=%h exp rsp=0 pot=%h",
                     load_rsp_valid, load_potential_out, pot_pat(7));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        idle_inputs();
        test_reset();
        test_save_load();
        test_collision();
        test_clear();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
